// File: rtl/phase_cmd_ctrl.sv
// UART command controller for the transducer phase-clock bank: parses WRITE/COMMIT/PING
// frames, keeps a shadow and a live offset bank, pulses reload on commit, replies per frame.
module phase_cmd_ctrl #(
  parameter int OUTPUTS  = 16,
  parameter int OFFSET_W = 24,
  parameter int DIVIDE   = 624,
  parameter int TIMEOUT  = 500000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   rx_data_i,
  input  logic                         rx_valid_i,
  output logic                         rx_ready_o,
  output logic [7:0]                   tx_data_o,
  output logic                         tx_valid_o,
  input  logic                         tx_ready_i,
  output logic [OUTPUTS*OFFSET_W-1:0]  offsets_o,
  output logic                         reload_o
);

  localparam int          CNT_W      = $clog2(TIMEOUT + 1);
  localparam int          CH_W       = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;
  localparam logic [23:0] MAX_OFFSET = 24'(2 * DIVIDE + 1);
  localparam logic [7:0]  ACK        = 8'h06;
  localparam logic [7:0]  NAK        = 8'h15;
  localparam logic [7:0]  OP_COMMIT  = 8'hC0;
  localparam logic [7:0]  OP_PING    = 8'hC1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_B2     = 3'd1,
    S_B1     = 3'd2,
    S_B0     = 3'd3,
    S_CHECK  = 3'd4,
    S_COMMIT = 3'd5,
    S_REPLY  = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [5:0]         ch_q, ch_d;
  logic [23:0]        data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               commit_ph_q, commit_ph_d;
  logic               rx_ready_q, rx_ready_d;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               reload_q, reload_d;
  logic               shadow_we_s;
  logic               live_load_s;
  logic               accept_s;
  logic               ch_ok_s;
  logic [OFFSET_W-1:0] shadow_q [OUTPUTS];
  logic [OFFSET_W-1:0] live_q   [OUTPUTS];

  assign accept_s = rx_valid_i && rx_ready_q;
  assign ch_ok_s  = ({1'b0, ch_q} < 7'(OUTPUTS));

  // Control registers; rx_ready and reload stay low while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ch_q        <= 6'd0;
      data_q      <= 24'd0;
      cnt_q       <= '0;
      commit_ph_q <= 1'b0;
      rx_ready_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      reload_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      commit_ph_q <= commit_ph_d;
      rx_ready_q  <= rx_ready_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      reload_q    <= reload_d;
    end
  end

  // Frame parser: next state, reply byte, bank write/load strobes.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    data_d      = data_q;
    cnt_d       = '0;
    commit_ph_d = 1'b0;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    reload_d    = 1'b1;
    shadow_we_s = 1'b0;
    live_load_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          if (rx_data_i[7:6] == 2'b10) begin
            ch_d    = rx_data_i[5:0];
            state_d = S_B2;
          end else if (rx_data_i == OP_COMMIT) begin
            state_d = S_COMMIT;
          end else if (rx_data_i == OP_PING) begin
            state_d    = S_REPLY;
            tx_valid_d = 1'b1;
            tx_data_d  = 8'(OUTPUTS);
          end else begin
            state_d    = S_REPLY;
            tx_valid_d = 1'b1;
            tx_data_d  = NAK;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_B2, S_B1, S_B0: begin
        if (accept_s) begin
          data_d  = {data_q[15:0], rx_data_i};
          cnt_d   = '0;
          state_d = (state_q == S_B2) ? S_B1 : ((state_q == S_B1) ? S_B0 : S_CHECK);
        end else if (cnt_q >= CNT_W'(TIMEOUT)) begin
          // Stalled frame is abandoned silently.
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = state_q;
        end
      end
      S_CHECK: begin
        if (ch_ok_s && (data_q <= MAX_OFFSET)) begin
          shadow_we_s = 1'b1;
          tx_data_d   = ACK;
        end else begin
          tx_data_d   = NAK;
        end
        tx_valid_d = 1'b1;
        state_d    = S_REPLY;
      end
      S_COMMIT: begin
        // Phase 0 loads the live bank and drops reload; phase 1 restores it and replies.
        if (!commit_ph_q) begin
          live_load_s = 1'b1;
          reload_d    = 1'b0;
          commit_ph_d = 1'b1;
          state_d     = S_COMMIT;
        end else begin
          tx_valid_d  = 1'b1;
          tx_data_d   = ACK;
          state_d     = S_REPLY;
        end
      end
      S_REPLY: begin
        if (tx_valid_q && tx_ready_i) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          state_d    = S_REPLY;
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  assign rx_ready_d = (state_d == S_IDLE) || (state_d == S_B2) ||
                      (state_d == S_B1) || (state_d == S_B0);

  // Shadow and live offset banks, both reset to the j*10 pattern.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < OUTPUTS; j++) begin
        shadow_q[j] <= OFFSET_W'(j * 10);
        live_q[j]   <= OFFSET_W'(j * 10);
      end
    end else begin
      if (shadow_we_s) begin
        shadow_q[ch_q[CH_W-1:0]] <= OFFSET_W'(data_q);
      end
      if (live_load_s) begin
        live_q <= shadow_q;
      end
    end
  end

  // Flatten the live bank onto the output bus.
  always_comb begin
    offsets_o = '0;
    for (int j = 0; j < OUTPUTS; j++) begin
      offsets_o[OFFSET_W*j +: OFFSET_W] = live_q[j];
    end
  end

  assign rx_ready_o = rx_ready_q;
  assign tx_valid_o = tx_valid_q;
  assign tx_data_o  = tx_data_q;
  assign reload_o   = reload_q;

endmodule

// File: tb/tb_phase_cmd_ctrl.sv
// Randomized frame stimulus for phase_cmd_ctrl, checked against a frame-level bank model.
`timescale 1ns/1ps
module tb_phase_cmd_ctrl;

  localparam int OUTPUTS  = 16;
  localparam int OFFSET_W = 24;
  localparam int DIVIDE   = 624;
  localparam int TIMEOUT  = 300;

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  logic [7:0]                  rx_data = 8'h00;
  logic                        rx_valid = 1'b0;
  logic                        rx_ready;
  logic [7:0]                  tx_data;
  logic                        tx_valid;
  logic                        tx_ready = 1'b0;
  logic [OUTPUTS*OFFSET_W-1:0] offsets;
  logic                        reload;

  int  checks = 0;
  int  failures = 0;
  int  m_shadow [OUTPUTS];
  int  m_live   [OUTPUTS];
  int  m_commits = 0;
  int  rl_cnt = 0;
  time rl_t = 0;
  time last_acc_t = 0;

  always #5 clk = ~clk;

  phase_cmd_ctrl #(
    .OUTPUTS(OUTPUTS), .OFFSET_W(OFFSET_W), .DIVIDE(DIVIDE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .offsets_o(offsets), .reload_o(reload)
  );

  // Every reload-low cycle outside reset is counted and timestamped.
  always @(negedge clk) begin
    if (rst && !reload) begin
      rl_cnt = rl_cnt + 1;
      rl_t   = $time;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < OUTPUTS; j++) begin
      m_shadow[j] = j * 10;
      m_live[j]   = j * 10;
    end
  endtask

  task automatic check_live();
    for (int j = 0; j < OUTPUTS; j++)
      check($sformatf("live%0d", j), 32'(offsets[OFFSET_W*j +: OFFSET_W]), m_live[j]);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(posedge clk);
    last_acc_t = $time;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // exp_lat: ns from accepting edge to the negedge where tx_valid is first seen (0 = skip).
  task automatic get_reply(input string tag, input logic [7:0] exp, input int exp_lat);
    int   n;
    int   hold;
    logic [7:0] d0;
    n = 0;
    while (!tx_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(tx_valid), 32'd1);
    if (tx_valid) begin
      if (exp_lat > 0) check({tag, "_latency"}, 32'($time - last_acc_t), 32'(exp_lat));
      check({tag, "_data"}, 32'(tx_data), 32'(exp));
      d0   = tx_data;
      hold = $urandom_range(0, 3);
      repeat (hold) @(negedge clk);
      check({tag, "_hold"}, {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, d0});
      tx_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tx_ready = 1'b0;
      check({tag, "_drop"}, 32'(tx_valid), 32'd0);
    end
  endtask

  task automatic do_write(input int ch, input int val, input int gap);
    logic [7:0] exp;
    logic [7:0] op;
    logic [23:0] v;
    v  = 24'(val);
    op = 8'h80 | 8'(ch);
    exp = (ch < OUTPUTS && val <= 2 * DIVIDE + 1) ? 8'h06 : 8'h15;
    if (exp == 8'h06) m_shadow[ch] = val;
    send_byte(op, gap);
    send_byte(v[23:16], gap);
    send_byte(v[15:8], gap);
    send_byte(v[7:0], gap);
    get_reply("write", exp, 15);
    check_live();
  endtask

  task automatic do_commit(input int gap);
    send_byte(8'hC0, gap);
    get_reply("commit", 8'h06, 25);
    for (int j = 0; j < OUTPUTS; j++) m_live[j] = m_shadow[j];
    m_commits++;
    check("reload_count", rl_cnt, m_commits);
    check("reload_when", 32'(rl_t - last_acc_t), 32'd15);
    check_live();
  endtask

  task automatic do_ping(input int gap);
    send_byte(8'hC1, gap);
    get_reply("ping", 8'(OUTPUTS), 0);
  endtask

  task automatic do_bad(input logic [7:0] op, input int gap);
    send_byte(op, gap);
    get_reply("bad", 8'h15, 0);
  endtask

  initial begin
    int   seen;
    int   kind;
    int   val;
    logic [7:0] op;
    logic [7:0] d0;

    // 1: reset state, then release.
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_reload", 32'(reload), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_ch0", 32'(offsets[0 +: 24]), 32'd0);
    check("rst_ch5", 32'(offsets[5*24 +: 24]), 32'd50);
    check("rst_ch15", 32'(offsets[15*24 +: 24]), 32'd150);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rel_reload", 32'(reload), 32'd1);
    check("rel_rx_ready", 32'(rx_ready), 32'd1);

    // 2: write then commit.
    do_write(3, 300, 0);
    do_commit(0);

    // 3: out-of-range value and channel.
    do_write(1, 1250, 0);
    do_write(16, 0, 0);
    do_commit(1);

    // 4: inter-byte timeout drops the frame silently.
    send_byte(8'h85, 0);
    send_byte(8'h00, 0);
    seen = 0;
    repeat (TIMEOUT + 10) begin
      @(negedge clk);
      if (tx_valid) seen = 1;
    end
    check("timeout_noreply", seen, 0);
    do_ping(0);
    do_commit(0);

    // 5: back-pressure on tx blocks the next frame.
    send_byte(8'hC1, 0);
    seen = 0;
    while (!tx_valid && seen < 100) begin
      @(negedge clk);
      seen++;
    end
    d0 = tx_data;
    check("bp_first", {24'd0, d0}, 32'(OUTPUTS));
    rx_data  = 8'hC1;
    rx_valid = 1'b1;
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (rx_ready || !tx_valid || tx_data !== d0) seen++;
    end
    check("bp_stall", seen, 0);
    tx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_ready = 1'b0;
    send_byte(8'hC1, 0);
    get_reply("bp_ping", 8'(OUTPUTS), 0);

    // 6: reset mid-frame drops everything.
    do_write(2, 777, 0);
    send_byte(8'h82, 0);
    send_byte(8'h00, 0);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    @(negedge clk);
    check("post_rst_tx_valid", 32'(tx_valid), 32'd0);
    check_live();
    do_commit(0);
    check("post_rst_live2", 32'(offsets[2*24 +: 24]), 32'd20);
    do_bad(8'h3F, 0);

    // Randomized frames.
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 7);
      if (kind <= 4) begin
        case ($urandom_range(0, 4))
          0:       val = 0;
          1:       val = 2 * DIVIDE + 1;
          2:       val = 2 * DIVIDE + 2;
          3:       val = $urandom_range(0, 1300);
          default: val = int'($urandom & 32'h00FF_FFFF);
        endcase
        do_write($urandom_range(0, 20), val, $urandom_range(0, 4));
      end else if (kind == 5) begin
        do_commit($urandom_range(0, 4));
      end else if (kind == 6) begin
        do_ping($urandom_range(0, 4));
      end else begin
        op = 8'($urandom_range(0, 255));
        while (op[7:6] == 2'b10 || op == 8'hC0 || op == 8'hC1) op = 8'($urandom_range(0, 255));
        do_bad(op, $urandom_range(0, 4));
      end
    end
    do_commit(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
